gaussian_window_ctrl: RTL and testbench
=======================================

// Module: gaussian_window_ctrl
// PURPOSE
// Frame sequencer for the 5x5 Gaussian blur operator. Accepts a raster pixel stream,
// keeps 4 line buffers and a 5x5 window register, and drives the operator's 200-bit
// window bus. Aligns the operator's 1-cycle registered result, buffers results in an
// output FIFO, and applies valid/ready backpressure upstream. One output per interior pixel.
// PARAMETERS
// IMG_WIDTH    64  pixels per line (>=5)
// IMG_HEIGHT   48  lines per frame (>=5)
// DWIDTH       8   pixel width
// OFIFO_DEPTH  4   output FIFO entries (>=4 gives full throughput)
// PORTS
// clock       in   1         rising-edge clock
// reset       in   1         synchronous, active-high
// start       in   1         pulse: begin frame (honoured in IDLE only)
// in_valid    in   1         input pixel valid
// in_ready    out  1         input pixel accepted when in_valid&&in_ready
// in_data     in   DWIDTH    input pixel, raster order
// win_data    out  25*DWIDTH window to operator; element (r,c) at [(r*5+c)*DWIDTH +: DWIDTH]
// op_result   in   DWIDTH    operator output (registered inside operator, 1 cycle)
// out_valid   out  1         result valid (FIFO non-empty)
// out_ready   in   1         downstream accepts result
// out_data    out  DWIDTH    FIFO head
// busy        out  1         state != IDLE
// frame_done  out  1         1-cycle pulse at end of frame
// BEHAVIOUR
// - Reset: state IDLE; in_ready, out_valid, busy, frame_done = 0; out_data, win_data = 0;
//   counters, pipeline flags v1/v2 and FIFO cleared. Reset mid-frame aborts; no output.
// - FSM: IDLE --start--> RUN (clears col,row) --last pixel accepted--> DRAIN
//   --(v1==0 && v2==0 && FIFO empty)--> IDLE, frame_done=1 that cycle. start outside IDLE ignored.
// - Accept (RUN only): shift window left one column; new column = 4 line-buffer taps at col
//   (rows 0..3, oldest first) plus in_data (row 4); write in_data into line buffers at col.
//   (4,4) = newest pixel, (0,0) = pixel at (row-4,col-4). col wraps W-1->0, row++.
// - Interior: accept with row>=4 && col>=4 sets v1 next cycle (win_data valid); v2 follows
//   v1 by 1 cycle; when v2=1, op_result is pushed to FIFO. Latency accept->out_valid = 3 cycles.
// - Output pixel corresponds to input (row-2,col-2); (W-4)*(H-4) outputs per frame, raster order.
// - in_ready = (state==RUN) && (fifo_count + v1 + v2 < OFIFO_DEPTH). Guarantees FIFO never
//   overflows; in-flight results never dropped. win_data held when no accept.
// - Simultaneous push and pop: count unchanged. Pop when out_valid&&out_ready.
// - Border accepts (row<4 or col<4) only update buffers/window; no v1.
// - Arithmetic: col/row counters $clog2(W)/$clog2(H) bits, compare with ==, no overflow.
// CONFIGURATION
// GAUSS_STALL_CNT_EN defined: adds port stall_count out 16: counts RUN cycles with
//   in_valid=1 && in_ready=0; saturates at 16'hFFFF; cleared by reset and by accepted start.
// Undefined: port and counter absent; all other behaviour identical.
// TESTING (bench replaces operator with 1-cycle reg of window centre (2,2))
// 1. Reset held 3 cycles -> in_ready=0, out_valid=0, busy=0, frame_done=0, win_data=0.
// 2. W=H=8, pixel=row*8+col, out_ready=1 -> 16 outputs 18,19,20,21,26,..,45; first v1 window
//    (0,0)=0,(4,4)=36; frame_done single pulse after last pop; busy then 0.
// 3. Same frame, out_ready=0 for 20 cycles mid-frame -> in_ready falls, FIFO holds 4,
//    no loss or duplication once released; same 16-value sequence.
// 4. Continuous in_valid, out_ready=1 -> one accept per cycle, in_ready never drops in RUN.
// 5. reset after 30 accepts, then start -> clean frame, exactly 16 correct outputs.
// 6. start pulsed during RUN/DRAIN -> ignored; with GAUSS_STALL_CNT_EN, test 3 yields
//    stall_count equal to counted in_valid&&!in_ready cycles.

Source files
------------

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer for a 5x5 Gaussian blur operator: line buffers, window, output FIFO.
// Optional stall counter is enabled with `define GAUSS_STALL_CNT_EN.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start                begin a frame (honoured in IDLE only)
//   in_valid/in_ready    raster pixel stream handshake, in_data pixel
//   win_data             25 window elements, (r,c) at [(r*5+c)*DWIDTH +: DWIDTH]
//   op_result            operator result, one cycle after a valid window
//   out_valid/out_ready  result handshake, out_data = FIFO head
//   busy                 frame in progress
//   frame_done           one-cycle pulse when the frame has fully drained
//   stall_count          (GAUSS_STALL_CNT_EN only) RUN cycles with input blocked
module gaussian_window_ctrl #(
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 48,
    parameter int DWIDTH      = 8,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_data,
    output logic [25*DWIDTH-1:0]  win_data,
    input  logic [DWIDTH-1:0]     op_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH-1:0]     out_data,
    output logic                  busy,
`ifdef GAUSS_STALL_CNT_EN
    output logic [15:0]           stall_count,
`endif
    output logic                  frame_done
);

    localparam int CW   = $clog2(IMG_WIDTH);
    localparam int RW   = $clog2(IMG_HEIGHT);
    localparam int PW   = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(OFIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              v1;
    logic              v2;
    logic              accept;
    logic              interior;

    logic [DWIDTH-1:0] lb  [4][IMG_WIDTH];
    logic [DWIDTH-1:0] win [5][5];

    logic [DWIDTH-1:0] mem [OFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CNTW-1:0]   fifo_count;
    logic [CNTW:0]     inflight;
    logic              push;
    logic              pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OFIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Results already in flight reserve a FIFO slot, so a push never overflows.
    assign inflight = (CNTW+1)'(fifo_count) + (CNTW+1)'(v1) + (CNTW+1)'(v2);
    assign in_ready = (state == S_RUN) && (inflight < (CNTW+1)'(OFIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign interior = (row >= RW'(4)) && (col >= CW'(4));
    assign busy     = (state != S_IDLE);

    assign push      = v2;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (col == CW'(IMG_WIDTH - 1)) begin
                            col <= '0;
                            if (row == RW'(IMG_HEIGHT - 1)) begin
                                row   <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!v1 && !v2 && (fifo_count == '0)) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // v1: window holds an interior neighbourhood; v2: operator result is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept && interior;
            v2 <= v1;
        end
    end

    // Each column of lb is a 4-deep vertical shift: lb[0] is row-4, lb[3] is row-1.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb[0][col] <= lb[1][col];
            lb[1][col] <= lb[2][col];
            lb[2][col] <= lb[3][col];
            lb[3][col] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    win[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    win[r][c] <= win[r][c+1];
            for (int r = 0; r < 4; r++)
                win[r][4] <= lb[r][col];
            win[4][4] <= in_data;
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                win_data[(r*5+c)*DWIDTH +: DWIDTH] = win[r][c];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < OFIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= op_result;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                fifo_count <= fifo_count + CNTW'(1);
            else if (!push && pop)
                fifo_count <= fifo_count - CNTW'(1);
        end
    end

`ifdef GAUSS_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_q <= '0;
        end else if ((state == S_RUN) && in_valid && !in_ready
                     && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Directed bench for gaussian_window_ctrl on an 8x8 frame.
// Operator stand-in: registered copy of the window centre.
module tb_gaussian_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int D  = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic [25*DW-1:0] win_data;
    logic [DW-1:0]  op_result = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           frame_done;
`ifdef GAUSS_STALL_CNT_EN
    logic [15:0]    stall_count;
`endif

    gaussian_window_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW), .OFIFO_DEPTH(D)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_data(win_data), .op_result(op_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
`ifdef GAUSS_STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) op_result <= win_data[(2*5+2)*DW +: DW];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clock) cyc++;

    int q[$];
    int acc, pops, done_cnt, stall_m;
    int first_cyc, last_cyc, first_out, last_out;
    bit win_pend;
    int wr_, wc_;
    logic [25*DW-1:0] first_win;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        acc = 0; pops = 0; done_cnt = 0; stall_m = 0;
        first_cyc = 0; last_cyc = 0; first_out = -1; last_out = -1;
        win_pend = 0; first_win = '0;
    endtask

    // Scoreboard: every cycle, compare windows after interior accepts and popped results.
    always @(negedge clock) begin
        if (!reset) begin
            if (win_pend) begin
                logic [25*DW-1:0] ew;
                ew = '0;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        ew[(r*5+c)*DW +: DW] = DW'((wr_-4+r)*W + (wc_-4+c));
                nvec++;
                if (win_data !== ew) begin
                    nerr++;
                    $display("FAIL window r%0d c%0d: got %h expected %h",
                             wr_, wc_, win_data, ew);
                end
                if (wr_ == 4 && wc_ == 4) first_win = win_data;
            end
            win_pend = 0;
            if (in_valid && in_ready) begin
                if (acc == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (acc / W >= 4 && acc % W >= 4) begin
                    win_pend = 1;
                    wr_ = acc / W;
                    wc_ = acc % W;
                end
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_output", int'(out_data), -1);
                end else begin
                    chk("out_data", int'(out_data), q.pop_front());
                end
                if (pops == 0) first_out = int'(out_data);
                last_out = int'(out_data);
                pops++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_busy", int'(busy), 0);
                chk("done_out_valid", int'(out_valid), 0);
                chk("done_left", q.size(), 0);
            end
            if (busy && in_valid && !in_ready) stall_m++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        clear_model();
    endtask

    task automatic start_frame();
        clear_model();
        for (int r = 2; r <= H - 3; r++)
            for (int c = 2; c <= W - 3; c++)
                q.push_back(r * W + c);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic send_frame(input int n);
        int idx;
        int t;
        bit a;
        idx = 0;
        t = 0;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_data  = '0;
        while (idx < n && t < 5000) begin
            @(negedge clock);
            a = in_valid && in_ready;
            @(posedge clock); #1;
            t++;
            if (a) idx++;
            in_data  = DW'(idx);
            in_valid = (idx < n);
        end
        in_valid = 1'b0;
        chk("send_timeout", int'(idx >= n), 1);
    endtask

    task automatic wait_acc(input int n);
        int t;
        t = 0;
        while (acc < n && t < 2000) begin
            @(posedge clock);
            t++;
        end
        chk("acc_timeout", int'(acc >= n), 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 1000) begin
            @(posedge clock);
            t++;
        end
        chk("done_timeout", int'(done_cnt > 0), 1);
        repeat (4) @(negedge clock);
        chk("done_pulses", done_cnt, 1);
        chk("idle_busy", int'(busy), 0);
        chk("pop_total", pops, (W - 4) * (H - 4));
    endtask

    initial begin
        clear_model();
        // reset state
        do_reset();
        @(negedge clock);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_win_zero", int'(win_data == '0), 1);

        // full frame, continuous input, no backpressure
        out_ready = 1'b1;
        start_frame();
        send_frame(W * H);
        wait_done();
        chk("first_out", first_out, 18);
        chk("last_out", last_out, 45);
        chk("win_00", int'(first_win[0 +: DW]), 0);
        chk("win_44", int'(first_win[24*DW +: DW]), 36);
        chk("win_22", int'(first_win[12*DW +: DW]), 18);
        chk("accept_span", last_cyc - first_cyc, W * H - 1);

        // downstream stalls for 20 cycles mid-frame
        start_frame();
        fork
            send_frame(W * H);
            begin
                wait_acc(40);
                #1 out_ready = 1'b0;
                repeat (20) @(posedge clock);
                @(negedge clock);
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_out_valid", int'(out_valid), 1);
                @(posedge clock); #1 out_ready = 1'b1;
            end
        join
        wait_done();
        chk("stall_first", first_out, 18);
        chk("stall_last", last_out, 45);
`ifdef GAUSS_STALL_CNT_EN
        chk("stall_count", int'(stall_count), stall_m);
        chk("stall_seen", int'(stall_m > 0), 1);
`endif

        // start pulses during RUN and DRAIN are ignored
        start_frame();
        fork
            send_frame(W * H);
            begin
                wait_acc(20);
                #1 start = 1'b1;
                @(posedge clock); #1 start = 1'b0;
            end
        join
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        chk("drain_busy", int'(busy), 1);
        wait_done();
        chk("ign_first", first_out, 18);
        chk("ign_last", last_out, 45);

        // reset mid-frame, then a clean frame
        start_frame();
        send_frame(30);
        chk("partial_acc", acc, 30);
        do_reset();
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_win_zero", int'(win_data == '0), 1);
        start_frame();
        send_frame(W * H);
        wait_done();
        chk("clean_first", first_out, 18);
        chk("clean_last", last_out, 45);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
